// File: rtl/timer_sched_ctrl.sv
// timer_sched_ctrl: grants N delay requesters, one at a time and round-robin, the single
// Avalon-MM interval timer. Define TIMER_SCHED_CANCEL_EN to add the cancel/cancel_ack ports.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | arbitrate pending requests, latch grant and period
// WR_P0..P3  | write period halfwords to timer addresses 2..5
// WR_CTRL    | write control: ITO=1, CONT=0, START=1
// WAIT_IRQ   | bus idle, wait for the timer interrupt
// STOP       | (cancel build) write control: STOP=1
// CLR_STAT   | write status to clear the timeout flag
// DONE       | done/cancel_ack pulse, advance round-robin pointer
module timer_sched_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       req,
    input  logic [N*CNT_W-1:0] delay,
`ifdef TIMER_SCHED_CANCEL_EN
    input  logic [N-1:0]       cancel,
    output logic [N-1:0]       cancel_ack,
`endif
    output logic [N-1:0]       grant,
    output logic [N-1:0]       done,
    output logic               busy,
    output logic [3:0]         tmr_address,
    output logic               tmr_chipselect,
    output logic               tmr_write_n,
    output logic [15:0]        tmr_writedata,
    input  logic               tmr_irq
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_P0,
        S_WR_P1,
        S_WR_P2,
        S_WR_P3,
        S_WR_CTRL,
        S_WAIT_IRQ,
        S_CLR_STAT,
        S_DONE
`ifdef TIMER_SCHED_CANCEL_EN
        , S_STOP
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    ptr, ptr_nxt;
    logic [IW-1:0]    gidx, gidx_nxt;
    logic [63:0]      period, period_nxt;
    logic [N-1:0]     grant_nxt;
    logic [N-1:0]     done_nxt;
    logic             bus_wr;
    logic [3:0]       addr_nxt;
    logic [15:0]      data_nxt;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    cand;
    logic [CNT_W-1:0] pick_delay;
    logic [CNT_W-1:0] pick_period;
`ifdef TIMER_SCHED_CANCEL_EN
    logic             cancelled, cancelled_nxt;
    logic [N-1:0]     cancel_ack_nxt;
`endif

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign busy = (state != S_IDLE);

    // First pending requester at or after the pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // A zero delay is clamped to one tick, giving period 0.
    always_comb begin
        pick_delay  = delay[int'(pick_idx)*CNT_W +: CNT_W];
        pick_period = (pick_delay == '0) ? '0 : pick_delay - CNT_W'(1);
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gidx_nxt   = gidx;
        period_nxt = period;
        grant_nxt  = grant;
        done_nxt   = '0;
`ifdef TIMER_SCHED_CANCEL_EN
        cancelled_nxt  = cancelled;
        cancel_ack_nxt = '0;
`endif
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_nxt  = S_WR_P0;
                    gidx_nxt   = pick_idx;
                    grant_nxt  = onehot(pick_idx);
                    period_nxt = 64'(pick_period);
`ifdef TIMER_SCHED_CANCEL_EN
                    cancelled_nxt = 1'b0;
`endif
                end
            end
            S_WR_P0:   state_nxt = S_WR_P1;
            S_WR_P1:   state_nxt = S_WR_P2;
            S_WR_P2:   state_nxt = S_WR_P3;
            S_WR_P3:   state_nxt = S_WR_CTRL;
            S_WR_CTRL: state_nxt = S_WAIT_IRQ;
            S_WAIT_IRQ: begin
`ifdef TIMER_SCHED_CANCEL_EN
                if (|(cancel & grant)) begin
                    state_nxt     = S_STOP;
                    cancelled_nxt = 1'b1;
                end else if (tmr_irq) begin
                    state_nxt = S_CLR_STAT;
                end
`else
                if (tmr_irq) state_nxt = S_CLR_STAT;
`endif
            end
`ifdef TIMER_SCHED_CANCEL_EN
            S_STOP:    state_nxt = S_CLR_STAT;
`endif
            S_CLR_STAT: begin
                // grant drops and the pulse fires together on entry to DONE.
                state_nxt = S_DONE;
                grant_nxt = '0;
`ifdef TIMER_SCHED_CANCEL_EN
                if (cancelled) cancel_ack_nxt = onehot(gidx);
                else           done_nxt       = onehot(gidx);
`else
                done_nxt = onehot(gidx);
`endif
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                ptr_nxt   = (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so the registered write lines up with its state.
    always_comb begin
        bus_wr   = 1'b1;
        addr_nxt = 4'd0;
        data_nxt = 16'h0000;
        case (state_nxt)
            S_WR_P0:    begin addr_nxt = 4'd2; data_nxt = period_nxt[15:0];  end
            S_WR_P1:    begin addr_nxt = 4'd3; data_nxt = period_nxt[31:16]; end
            S_WR_P2:    begin addr_nxt = 4'd4; data_nxt = period_nxt[47:32]; end
            S_WR_P3:    begin addr_nxt = 4'd5; data_nxt = period_nxt[63:48]; end
            S_WR_CTRL:  begin addr_nxt = 4'd1; data_nxt = 16'h0005;          end
`ifdef TIMER_SCHED_CANCEL_EN
            S_STOP:     begin addr_nxt = 4'd1; data_nxt = 16'h0008;          end
`endif
            S_CLR_STAT: begin addr_nxt = 4'd0; data_nxt = 16'h0000;          end
            default:    bus_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            ptr            <= '0;
            gidx           <= '0;
            period         <= '0;
            grant          <= '0;
            done           <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_address    <= 4'd0;
            tmr_writedata  <= 16'h0000;
`ifdef TIMER_SCHED_CANCEL_EN
            cancelled      <= 1'b0;
            cancel_ack     <= '0;
`endif
        end else begin
            state          <= state_nxt;
            ptr            <= ptr_nxt;
            gidx           <= gidx_nxt;
            period         <= period_nxt;
            grant          <= grant_nxt;
            done           <= done_nxt;
            tmr_chipselect <= bus_wr;
            tmr_write_n    <= ~bus_wr;
            tmr_address    <= addr_nxt;
            tmr_writedata  <= data_nxt;
`ifdef TIMER_SCHED_CANCEL_EN
            cancelled      <= cancelled_nxt;
            cancel_ack     <= cancel_ack_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Scoreboard bench for timer_sched_ctrl: expected timer writes and done pulses are queued by
// the stimulus and popped by a monitor; a small interval-timer model answers the bus.
module tb_timer_sched_ctrl;
    localparam int N     = 4;
    localparam int CNT_W = 32;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [N-1:0]       req = '0;
    logic [N*CNT_W-1:0] delay = '0;
    logic [N-1:0]       grant, done;
    logic               busy;
    logic [3:0]         tmr_address;
    logic               tmr_chipselect, tmr_write_n;
    logic [15:0]        tmr_writedata;
    logic               tmr_irq;
    logic               model_irq = 1'b0;
    logic               force_irq = 1'b0;
    logic               hold = 1'b0;
`ifdef TIMER_SCHED_CANCEL_EN
    logic [N-1:0]       cancel = '0;
    logic [N-1:0]       cancel_ack;
`endif

    assign tmr_irq = model_irq | force_irq;

    timer_sched_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .delay(delay),
`ifdef TIMER_SCHED_CANCEL_EN
        .cancel(cancel), .cancel_ack(cancel_ack),
`endif
        .grant(grant), .done(done), .busy(busy),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Interval timer: fires P+1 ticks after the START write, cleared by a status write.
    logic [63:0] per = '0;
    logic [64:0] cnt = '0;
    logic        counting = 1'b0;
    always @(posedge clk) begin
        if (!reset_n) begin
            counting  <= 1'b0;
            model_irq <= 1'b0;
        end else if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                4'd0: model_irq <= 1'b0;
                4'd1: begin
                    if (tmr_writedata[3]) counting <= 1'b0;
                    else if (tmr_writedata[2] && !hold) begin
                        cnt      <= {1'b0, per} + 65'd1;
                        counting <= 1'b1;
                    end
                end
                4'd2: per[15:0]  <= tmr_writedata;
                4'd3: per[31:16] <= tmr_writedata;
                4'd4: per[47:32] <= tmr_writedata;
                4'd5: per[63:48] <= tmr_writedata;
                default: ;
            endcase
        end else if (counting) begin
            if (cnt == 65'd1) begin
                model_irq <= 1'b1;
                counting  <= 1'b0;
            end else begin
                cnt <= cnt - 65'd1;
            end
        end
    end

    typedef struct packed {
        logic [3:0]   a;
        logic [15:0]  d;
        logic [N-1:0] g;
    } wr_t;
    typedef struct packed {
        logic [N-1:0] v;
        int           c;
    } dn_t;

    wr_t exp_wr[$];
    dn_t exp_dn[$];
    int  vectors = 0;
    int  miscompares = 0;
    bit  grant2_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        wr_t w;
        dn_t d;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (tmr_chipselect && !tmr_write_n) begin
                    if (exp_wr.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none (cycle %0d)",
                                 tmr_address, tmr_writedata, cyc);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wr_addr", 64'(tmr_address), 64'(w.a));
                        chk("wr_data", 64'(tmr_writedata), 64'(w.d));
                        chk("wr_grant", 64'(grant), 64'(w.g));
                    end
                end
                if (done != '0) begin
                    if (exp_dn.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done: got 0x%0h, expected none (cycle %0d)", done, cyc);
                    end else begin
                        d = exp_dn.pop_front();
                        chk("done_vec", 64'(done), 64'(d.v));
                        chk("done_cycle", 64'(cyc), 64'(d.c));
                    end
                end
                chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
                if (grant[2]) grant2_seen = 1'b1;
            end
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_txn(input int idx, input logic [CNT_W-1:0] dly, input bit completes, input int done_cyc);
        logic [N-1:0] g;
        logic [63:0]  p;
        dn_t          d;
        g = '0;
        g[idx] = 1'b1;
        p = (dly == '0) ? 64'd0 : 64'(dly) - 64'd1;
        exp_wr.push_back('{a: 4'd2, d: p[15:0],  g: g});
        exp_wr.push_back('{a: 4'd3, d: p[31:16], g: g});
        exp_wr.push_back('{a: 4'd4, d: p[47:32], g: g});
        exp_wr.push_back('{a: 4'd5, d: p[63:48], g: g});
        exp_wr.push_back('{a: 4'd1, d: 16'h0005, g: g});
        if (completes) begin
            exp_wr.push_back('{a: 4'd0, d: 16'h0000, g: g});
            d.v = g;
            d.c = done_cyc;
            exp_dn.push_back(d);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_cs"}, 64'(tmr_chipselect), 64'd0);
        chk({tag, "_write_n"}, 64'(tmr_write_n), 64'd1);
        chk({tag, "_addr"}, 64'(tmr_address), 64'd0);
        chk({tag, "_data"}, 64'(tmr_writedata), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_reset_vals("reset");

        // Single request, delay 10: done at +18, idle the cycle after.
        wait_cyc(cyc + 1);
        n = cyc;
        delay[0*CNT_W +: CNT_W] = 32'd10;
        req[0] = 1'b1;
        push_txn(0, 32'd10, 1'b1, n + 18);
        wait_cyc(n + 18);
        chk("single_busy_in_done", 64'(busy), 64'd1);
        req[0] = 1'b0;
        wait_cyc(n + 19);
        chk("single_busy_after", 64'(busy), 64'd0);

        // Wide delay halfwords, then reset while waiting on the timer.
        wait_cyc(cyc + 2);
        n = cyc;
        delay[0*CNT_W +: CNT_W] = 32'h1234_5678;
        req[0] = 1'b1;
        push_txn(0, 32'h1234_5678, 1'b0, 0);
        wait_cyc(n + 12);
        req[0] = 1'b0;
        chk("wait_busy", 64'(busy), 64'd1);
        wait_cyc(n + 20);
        reset_n = 1'b0;
        wait_cyc(n + 21);
        reset_n = 1'b1;
        chk_reset_vals("midreset");
        wait_cyc(n + 30);
        chk("midreset_idle", 64'(busy), 64'd0);

        // Round robin from pointer 0 with req=1011 held, delay 3 each.
        n = cyc;
        delay[0*CNT_W +: CNT_W] = 32'd3;
        delay[1*CNT_W +: CNT_W] = 32'd3;
        delay[3*CNT_W +: CNT_W] = 32'd3;
        req = 4'b1011;
        push_txn(0, 32'd3, 1'b1, n + 11);
        push_txn(1, 32'd3, 1'b1, n + 23);
        push_txn(3, 32'd3, 1'b1, n + 35);
        push_txn(0, 32'd3, 1'b1, n + 47);
        wait_cyc(n + 47);
        req = '0;
        wait_cyc(n + 49);
        chk("rr_busy_after", 64'(busy), 64'd0);

        // delay 0 is clamped to one tick: period 0, done at +9.
        wait_cyc(cyc + 2);
        n = cyc;
        delay[0*CNT_W +: CNT_W] = 32'd0;
        req[0] = 1'b1;
        push_txn(0, 32'd0, 1'b1, n + 9);
        wait_cyc(n + 9);
        req[0] = 1'b0;
        wait_cyc(n + 10);
        chk("zero_busy_after", 64'(busy), 64'd0);

        // Late irq: timer silent for >500 cycles; req[2] pulsed while busy is never granted.
        hold = 1'b1;
        wait_cyc(cyc + 2);
        n = cyc;
        delay[1*CNT_W +: CNT_W] = 32'd5;
        req[1] = 1'b1;
        push_txn(1, 32'd5, 1'b0, 0);
        wait_cyc(n + 10);
        req[2] = 1'b1;
        wait_cyc(n + 11);
        req[2] = 1'b0;
        wait_cyc(n + 506);
        chk("late_busy", 64'(busy), 64'd1);
        chk("late_grant", 64'(grant), 64'b0010);
        k = cyc;
        force_irq = 1'b1;
        exp_wr.push_back('{a: 4'd0, d: 16'h0000, g: 4'b0010});
        exp_dn.push_back('{v: 4'b0010, c: k + 2});
        wait_cyc(k + 1);
        force_irq = 1'b0;
        wait_cyc(k + 2);
        req[1] = 1'b0;
        wait_cyc(k + 8);
        chk("late_busy_after", 64'(busy), 64'd0);
        chk("dropped_req2_granted", 64'(grant2_seen), 64'd0);
        hold = 1'b0;

`ifdef TIMER_SCHED_CANCEL_EN
        // Cancel in WAIT_IRQ: STOP write, status clear, cancel_ack instead of done.
        n = cyc;
        delay[3*CNT_W +: CNT_W] = 32'd100;
        req[3] = 1'b1;
        push_txn(3, 32'd100, 1'b0, 0);
        exp_wr.push_back('{a: 4'd1, d: 16'h0008, g: 4'b1000});
        exp_wr.push_back('{a: 4'd0, d: 16'h0000, g: 4'b1000});
        wait_cyc(n + 10);
        cancel = 4'b1000;
        wait_cyc(n + 11);
        cancel = '0;
        wait_cyc(n + 13);
        chk("cancel_ack", 64'(cancel_ack), 64'b1000);
        chk("cancel_done", 64'(done), 64'd0);
        req[3] = 1'b0;
        wait_cyc(n + 14);
        chk("cancel_ack_pulse", 64'(cancel_ack), 64'd0);
        chk("cancel_busy_after", 64'(busy), 64'd0);
`endif

        wait_cyc(cyc + 5);
        chk("writes_outstanding", 64'(exp_wr.size()), 64'd0);
        chk("dones_outstanding", 64'(exp_dn.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
